// File: rtl/tl_ad_buffer.sv
// A/D channel decoupling FIFOs for a single-beat TL-UH client edge, with an outstanding-request cap.
// Optional TL_AD_BUF_FLOW_EN: zero-latency flow-through while a FIFO is empty.
module tl_ad_buffer #(
  parameter int unsigned A_DEPTH      = 2,
  parameter int unsigned D_DEPTH      = 2,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        auto_in_a_valid,
  output logic        auto_in_a_ready,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [2:0]  auto_in_a_bits_size,
  input  logic [6:0]  auto_in_a_bits_source,
  input  logic [31:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  output logic        auto_out_a_valid,
  input  logic        auto_out_a_ready,
  output logic [2:0]  auto_out_a_bits_opcode,
  output logic [2:0]  auto_out_a_bits_param,
  output logic [2:0]  auto_out_a_bits_size,
  output logic [6:0]  auto_out_a_bits_source,
  output logic [31:0] auto_out_a_bits_address,
  output logic [7:0]  auto_out_a_bits_mask,
  output logic [63:0] auto_out_a_bits_data,
  output logic        auto_out_a_bits_corrupt,
  input  logic        auto_out_d_valid,
  output logic        auto_out_d_ready,
  input  logic [2:0]  auto_out_d_bits_opcode,
  input  logic [1:0]  auto_out_d_bits_param,
  input  logic [2:0]  auto_out_d_bits_size,
  input  logic [6:0]  auto_out_d_bits_source,
  input  logic [2:0]  auto_out_d_bits_sink,
  input  logic        auto_out_d_bits_denied,
  input  logic [63:0] auto_out_d_bits_data,
  input  logic        auto_out_d_bits_corrupt,
  output logic        auto_in_d_valid,
  input  logic        auto_in_d_ready,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_param,
  output logic [2:0]  auto_in_d_bits_size,
  output logic [6:0]  auto_in_d_bits_source,
  output logic [2:0]  auto_in_d_bits_sink,
  output logic        auto_in_d_bits_denied,
  output logic [63:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt
);

  localparam int unsigned A_W  = 121;
  localparam int unsigned D_W  = 84;
  localparam int unsigned A_PW = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
  localparam int unsigned D_PW = (D_DEPTH > 1) ? $clog2(D_DEPTH) : 1;
  localparam int unsigned A_CW = $clog2(A_DEPTH + 1);
  localparam int unsigned D_CW = $clog2(D_DEPTH + 1);

  localparam logic [A_PW-1:0] A_LAST   = A_PW'(A_DEPTH - 1);
  localparam logic [D_PW-1:0] D_LAST   = D_PW'(D_DEPTH - 1);
  localparam logic [A_CW-1:0] A_FULL   = A_CW'(A_DEPTH);
  localparam logic [D_CW-1:0] D_FULL   = D_CW'(D_DEPTH);
  localparam logic [6:0]      MAX_INFL = 7'(MAX_INFLIGHT);

  logic [A_W-1:0]  a_mem [A_DEPTH];
  logic [A_PW-1:0] a_wptr_q, a_rptr_q;
  logic [A_CW-1:0] a_cnt_q;
  logic [A_W-1:0]  a_in_bits, a_head;
  logic            a_full, a_empty, a_avail, a_bypass;
  logic            a_in_fire, a_out_fire, a_push, a_pop;

  logic [D_W-1:0]  d_mem [D_DEPTH];
  logic [D_PW-1:0] d_wptr_q, d_rptr_q;
  logic [D_CW-1:0] d_cnt_q;
  logic [D_W-1:0]  d_in_bits, d_head;
  logic            d_full, d_empty, d_avail, d_bypass;
  logic            d_in_fire, d_out_fire, d_push, d_pop;

  logic [6:0]      inflight_q;
  logic            inflight_ok;

  assign a_in_bits = {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                      auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                      auto_in_a_bits_data, auto_in_a_bits_corrupt};
  assign d_in_bits = {auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
                      auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
                      auto_out_d_bits_data, auto_out_d_bits_corrupt};

  assign a_full  = (a_cnt_q == A_FULL);
  assign a_empty = (a_cnt_q == '0);
  assign d_full  = (d_cnt_q == D_FULL);
  assign d_empty = (d_cnt_q == '0);

  assign auto_in_a_ready  = !a_full;
  assign auto_out_d_ready = !d_full;
  assign inflight_ok      = (inflight_q < MAX_INFL);

`ifdef TL_AD_BUF_FLOW_EN
  // An empty FIFO presents the incoming beat directly; it is stored only if not taken.
  assign a_head   = a_empty ? a_in_bits : a_mem[a_rptr_q];
  assign a_avail  = a_empty ? auto_in_a_valid : 1'b1;
  assign a_bypass = a_empty && a_out_fire;
  assign d_head   = d_empty ? d_in_bits : d_mem[d_rptr_q];
  assign d_avail  = d_empty ? auto_out_d_valid : 1'b1;
  assign d_bypass = d_empty && d_out_fire;
`else
  assign a_head   = a_mem[a_rptr_q];
  assign a_avail  = !a_empty;
  assign a_bypass = 1'b0;
  assign d_head   = d_mem[d_rptr_q];
  assign d_avail  = !d_empty;
  assign d_bypass = 1'b0;
`endif

  assign auto_out_a_valid = a_avail && inflight_ok;
  assign auto_in_d_valid  = d_avail;

  assign a_in_fire  = auto_in_a_valid && auto_in_a_ready;
  assign a_out_fire = auto_out_a_valid && auto_out_a_ready;
  assign d_in_fire  = auto_out_d_valid && auto_out_d_ready;
  assign d_out_fire = auto_in_d_valid && auto_in_d_ready;

  assign a_push = a_in_fire && !a_bypass;
  assign a_pop  = a_out_fire && !a_bypass;
  assign d_push = d_in_fire && !d_bypass;
  assign d_pop  = d_out_fire && !d_bypass;

  assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
          auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
          auto_out_a_bits_data, auto_out_a_bits_corrupt} = a_head;
  assign {auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
          auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
          auto_in_d_bits_data, auto_in_d_bits_corrupt} = d_head;

  always_ff @(posedge clock) begin
    if (a_push) a_mem[a_wptr_q] <= a_in_bits;
    if (d_push) d_mem[d_wptr_q] <= d_in_bits;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_wptr_q <= '0;
      a_rptr_q <= '0;
      a_cnt_q  <= '0;
    end else begin
      if (a_push) a_wptr_q <= (a_wptr_q == A_LAST) ? '0 : a_wptr_q + A_PW'(1);
      if (a_pop)  a_rptr_q <= (a_rptr_q == A_LAST) ? '0 : a_rptr_q + A_PW'(1);
      case ({a_push, a_pop})
        2'b10:   a_cnt_q <= a_cnt_q + A_CW'(1);
        2'b01:   a_cnt_q <= a_cnt_q - A_CW'(1);
        default: a_cnt_q <= a_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_wptr_q <= '0;
      d_rptr_q <= '0;
      d_cnt_q  <= '0;
    end else begin
      if (d_push) d_wptr_q <= (d_wptr_q == D_LAST) ? '0 : d_wptr_q + D_PW'(1);
      if (d_pop)  d_rptr_q <= (d_rptr_q == D_LAST) ? '0 : d_rptr_q + D_PW'(1);
      case ({d_push, d_pop})
        2'b10:   d_cnt_q <= d_cnt_q + D_CW'(1);
        2'b01:   d_cnt_q <= d_cnt_q - D_CW'(1);
        default: d_cnt_q <= d_cnt_q;
      endcase
    end
  end

  // A D beat with nothing outstanding is a protocol error; hold at zero rather than wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight_q <= '0;
    end else if (a_out_fire && !d_out_fire) begin
      inflight_q <= inflight_q + 7'd1;
    end else if (!a_out_fire && d_out_fire && (inflight_q != '0)) begin
      inflight_q <= inflight_q - 7'd1;
    end
  end

  a_size_legal: assert property (@(posedge clock) disable iff (!reset)
    auto_in_a_valid |-> (auto_in_a_bits_size <= 3'd3));
  a_valid_held: assert property (@(posedge clock) disable iff (!reset)
    (auto_in_a_valid && !auto_in_a_ready) |=> auto_in_a_valid);
  d_valid_held: assert property (@(posedge clock) disable iff (!reset)
    (auto_out_d_valid && !auto_out_d_ready) |=> auto_out_d_valid);
  d_has_request: assert property (@(posedge clock) disable iff (!reset)
    d_out_fire |-> (inflight_q != '0));

endmodule

// File: tb/tb_tl_ad_buffer.sv
// Bench for tl_ad_buffer: directed vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_tl_ad_buffer;

  localparam int A_DEPTH = 2;
  localparam int D_DEPTH = 2;
  localparam int MAX_INFLIGHT = 8;
`ifdef TL_AD_BUF_FLOW_EN
  localparam bit FLOW = 1'b1;
`else
  localparam bit FLOW = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        auto_in_a_valid, auto_in_a_ready;
  logic [2:0]  auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size;
  logic [6:0]  auto_in_a_bits_source;
  logic [31:0] auto_in_a_bits_address;
  logic [7:0]  auto_in_a_bits_mask;
  logic [63:0] auto_in_a_bits_data;
  logic        auto_in_a_bits_corrupt;
  logic        auto_out_a_valid, auto_out_a_ready;
  logic [2:0]  auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size;
  logic [6:0]  auto_out_a_bits_source;
  logic [31:0] auto_out_a_bits_address;
  logic [7:0]  auto_out_a_bits_mask;
  logic [63:0] auto_out_a_bits_data;
  logic        auto_out_a_bits_corrupt;
  logic        auto_out_d_valid, auto_out_d_ready;
  logic [2:0]  auto_out_d_bits_opcode;
  logic [1:0]  auto_out_d_bits_param;
  logic [2:0]  auto_out_d_bits_size;
  logic [6:0]  auto_out_d_bits_source;
  logic [2:0]  auto_out_d_bits_sink;
  logic        auto_out_d_bits_denied;
  logic [63:0] auto_out_d_bits_data;
  logic        auto_out_d_bits_corrupt;
  logic        auto_in_d_valid, auto_in_d_ready;
  logic [2:0]  auto_in_d_bits_opcode;
  logic [1:0]  auto_in_d_bits_param;
  logic [2:0]  auto_in_d_bits_size;
  logic [6:0]  auto_in_d_bits_source;
  logic [2:0]  auto_in_d_bits_sink;
  logic        auto_in_d_bits_denied;
  logic [63:0] auto_in_d_bits_data;
  logic        auto_in_d_bits_corrupt;

  logic [120:0] a_in_vec, a_out_vec;
  logic [83:0]  d_in_vec, d_out_vec;

  assign a_in_vec  = {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                      auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                      auto_in_a_bits_data, auto_in_a_bits_corrupt};
  assign a_out_vec = {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
                      auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
                      auto_out_a_bits_data, auto_out_a_bits_corrupt};
  assign d_in_vec  = {auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
                      auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
                      auto_out_d_bits_data, auto_out_d_bits_corrupt};
  assign d_out_vec = {auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
                      auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
                      auto_in_d_bits_data, auto_in_d_bits_corrupt};

  tl_ad_buffer #(
    .A_DEPTH      (A_DEPTH),
    .D_DEPTH      (D_DEPTH),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .auto_in_a_valid         (auto_in_a_valid),
    .auto_in_a_ready         (auto_in_a_ready),
    .auto_in_a_bits_opcode   (auto_in_a_bits_opcode),
    .auto_in_a_bits_param    (auto_in_a_bits_param),
    .auto_in_a_bits_size     (auto_in_a_bits_size),
    .auto_in_a_bits_source   (auto_in_a_bits_source),
    .auto_in_a_bits_address  (auto_in_a_bits_address),
    .auto_in_a_bits_mask     (auto_in_a_bits_mask),
    .auto_in_a_bits_data     (auto_in_a_bits_data),
    .auto_in_a_bits_corrupt  (auto_in_a_bits_corrupt),
    .auto_out_a_valid        (auto_out_a_valid),
    .auto_out_a_ready        (auto_out_a_ready),
    .auto_out_a_bits_opcode  (auto_out_a_bits_opcode),
    .auto_out_a_bits_param   (auto_out_a_bits_param),
    .auto_out_a_bits_size    (auto_out_a_bits_size),
    .auto_out_a_bits_source  (auto_out_a_bits_source),
    .auto_out_a_bits_address (auto_out_a_bits_address),
    .auto_out_a_bits_mask    (auto_out_a_bits_mask),
    .auto_out_a_bits_data    (auto_out_a_bits_data),
    .auto_out_a_bits_corrupt (auto_out_a_bits_corrupt),
    .auto_out_d_valid        (auto_out_d_valid),
    .auto_out_d_ready        (auto_out_d_ready),
    .auto_out_d_bits_opcode  (auto_out_d_bits_opcode),
    .auto_out_d_bits_param   (auto_out_d_bits_param),
    .auto_out_d_bits_size    (auto_out_d_bits_size),
    .auto_out_d_bits_source  (auto_out_d_bits_source),
    .auto_out_d_bits_sink    (auto_out_d_bits_sink),
    .auto_out_d_bits_denied  (auto_out_d_bits_denied),
    .auto_out_d_bits_data    (auto_out_d_bits_data),
    .auto_out_d_bits_corrupt (auto_out_d_bits_corrupt),
    .auto_in_d_valid         (auto_in_d_valid),
    .auto_in_d_ready         (auto_in_d_ready),
    .auto_in_d_bits_opcode   (auto_in_d_bits_opcode),
    .auto_in_d_bits_param    (auto_in_d_bits_param),
    .auto_in_d_bits_size     (auto_in_d_bits_size),
    .auto_in_d_bits_source   (auto_in_d_bits_source),
    .auto_in_d_bits_sink     (auto_in_d_bits_sink),
    .auto_in_d_bits_denied   (auto_in_d_bits_denied),
    .auto_in_d_bits_data     (auto_in_d_bits_data),
    .auto_in_d_bits_corrupt  (auto_in_d_bits_corrupt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       iv;
    logic [6:0] isrc;
    logic       ordy;
    logic       exp_irdy;
    logic       exp_ov;
    logic [6:0] exp_osrc;
  } a_vec_t;

  int checks = 0;
  int errors = 0;
  bit feed_en = 1'b0;
  int feed_n  = 0;
  int feed_idx = 0;
  bit feed_fire;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [120:0] mk_a(input logic [6:0] src);
    return {3'd4, 3'd0, 3'd3, src, 32'h1000_0000 + {25'd0, src}, 8'hff, {57'd0, src}, 1'b0};
  endfunction

  function automatic logic [120:0] rand_a();
    return {3'($urandom), 3'($urandom), 3'($urandom_range(0, 3)), 7'($urandom), 32'($urandom),
            8'($urandom), {32'($urandom), 32'($urandom)}, 1'($urandom)};
  endfunction

  function automatic logic [83:0] rand_d(input logic [6:0] src);
    return {3'($urandom), 2'($urandom), 3'($urandom_range(0, 3)), src, 3'($urandom),
            1'($urandom), {32'($urandom), 32'($urandom)}, 1'($urandom)};
  endfunction

  task automatic set_a(input logic [120:0] b);
    {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size, auto_in_a_bits_source,
     auto_in_a_bits_address, auto_in_a_bits_mask, auto_in_a_bits_data,
     auto_in_a_bits_corrupt} = b;
  endtask

  task automatic set_d(input logic [83:0] b);
    {auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size, auto_out_d_bits_source,
     auto_out_d_bits_sink, auto_out_d_bits_denied, auto_out_d_bits_data,
     auto_out_d_bits_corrupt} = b;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    feed_en = 1'b0;
    feed_idx = 0;
    auto_in_a_valid = 1'b0;
    auto_out_a_ready = 1'b0;
    auto_out_d_valid = 1'b0;
    auto_in_d_ready = 1'b0;
    set_a('0);
    set_d('0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // The feeder offers beats 0..feed_n-1 in order, holding each until accepted.
  task automatic begin_cycle();
    @(negedge clock);
    if (feed_en) begin
      auto_in_a_valid = (feed_idx < feed_n);
      set_a(mk_a(7'(feed_idx)));
    end
  endtask

  task automatic end_cycle();
    feed_fire = feed_en && auto_in_a_valid && auto_in_a_ready;
    @(posedge clock);
    if (feed_fire) feed_idx++;
  endtask

  initial begin
    a_vec_t a_tab[7];
    logic [83:0]  dexp[3];
    logic [120:0] aq[$];
    logic [83:0]  dq[$];
    logic [6:0]   pool[$];
    int infl, fires, got, d_sent;
    bit a_hold, d_hold, odf;
    bit e_oav, e_iar, e_idv, e_odr, oaf, iaf, idf, a_byp, d_byp;
    logic [120:0] e_ahead;
    logic [83:0]  e_dhead;

    a_tab[0] = '{1'b1, 7'h01, 1'b0, 1'b1, 1'b0, 7'h00};
    a_tab[1] = '{1'b1, 7'h02, 1'b0, 1'b1, 1'b1, 7'h01};
    a_tab[2] = '{1'b1, 7'h03, 1'b0, 1'b0, 1'b1, 7'h01};
    a_tab[3] = '{1'b1, 7'h03, 1'b1, 1'b0, 1'b1, 7'h01};
    a_tab[4] = '{1'b1, 7'h03, 1'b1, 1'b1, 1'b1, 7'h02};
    a_tab[5] = '{1'b0, 7'h00, 1'b1, 1'b1, 1'b1, 7'h03};
    a_tab[6] = '{1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 7'h00};

    // Reset values
    do_reset();
    reset = 1'b0;
    #1;
    chk("rst_out_a_valid", 128'(auto_out_a_valid), 128'(0));
    chk("rst_in_a_ready", 128'(auto_in_a_ready), 128'(1));
    chk("rst_out_d_ready", 128'(auto_out_d_ready), 128'(1));
    chk("rst_in_d_valid", 128'(auto_in_d_valid), 128'(0));

    // Latency of a single A beat
    do_reset();
    begin_cycle();
    auto_in_a_valid = 1'b1;
    set_a({3'd4, 3'd0, 3'd3, 7'h05, 32'h8000_0000, 8'hff, 64'h0000_0000_DEAD_BEEF, 1'b0});
    auto_out_a_ready = FLOW;
    #1;
    chk("lat_valid_n", 128'(auto_out_a_valid), 128'(FLOW));
    if (FLOW) begin
      chk("lat_flow_addr", 128'(auto_out_a_bits_address), 128'(32'h8000_0000));
      chk("lat_flow_data", 128'(auto_out_a_bits_data), 128'(64'hDEAD_BEEF));
    end
    end_cycle();
    begin_cycle();
    auto_in_a_valid = 1'b0;
    auto_out_a_ready = 1'b0;
    #1;
    chk("lat_valid_n1", 128'(auto_out_a_valid), 128'(!FLOW));
    if (!FLOW) begin
      chk("lat_addr", 128'(auto_out_a_bits_address), 128'(32'h8000_0000));
      chk("lat_data", 128'(auto_out_a_bits_data), 128'(64'hDEAD_BEEF));
    end
    end_cycle();

`ifndef TL_AD_BUF_FLOW_EN
    // A backpressure and release, vector table
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      auto_in_a_valid = a_tab[i].iv;
      set_a(mk_a(a_tab[i].isrc));
      auto_out_a_ready = a_tab[i].ordy;
      #1;
      chk($sformatf("tab%0d_in_a_ready", i), 128'(auto_in_a_ready), 128'(a_tab[i].exp_irdy));
      chk($sformatf("tab%0d_out_a_valid", i), 128'(auto_out_a_valid), 128'(a_tab[i].exp_ov));
      if (a_tab[i].exp_ov)
        chk($sformatf("tab%0d_out_a_src", i), 128'(auto_out_a_bits_source),
            128'(a_tab[i].exp_osrc));
      @(posedge clock);
    end
`endif

    // Asynchronous reset with two A entries queued
    do_reset();
    feed_en = 1'b1;
    feed_n = 2;
    repeat (3) begin
      begin_cycle();
      #1;
      end_cycle();
    end
    begin_cycle();
    #1;
    chk("mid_pre_valid", 128'(auto_out_a_valid), 128'(1));
    chk("mid_pre_ready", 128'(auto_in_a_ready), 128'(0));
    #1;
    reset = 1'b0;
    #1;
    chk("mid_out_a_valid", 128'(auto_out_a_valid), 128'(0));
    chk("mid_in_a_ready", 128'(auto_in_a_ready), 128'(1));
    chk("mid_in_d_valid", 128'(auto_in_d_valid), 128'(0));

    // D backpressure with three A requests outstanding
    do_reset();
    feed_en = 1'b1;
    feed_n = 3;
    auto_out_a_ready = 1'b1;
    repeat (6) begin
      begin_cycle();
      #1;
      end_cycle();
    end
    feed_en = 1'b0;
    for (int k = 0; k < 3; k++)
      dexp[k] = {3'd1, 2'd0, 3'd3, 7'(k), 3'(k + 1), 1'(k), {32'($urandom), 32'($urandom)}, 1'b0};
    for (int k = 0; k < 3; k++) begin
      begin_cycle();
      auto_in_a_valid = 1'b0;
      auto_out_d_valid = 1'b1;
      set_d(dexp[k]);
      #1;
      chk($sformatf("dbp%0d_out_d_ready", k), 128'(auto_out_d_ready), 128'(k < 2));
      end_cycle();
    end
    d_sent = 2;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      begin_cycle();
      auto_in_d_ready = 1'b1;
      auto_out_d_valid = (d_sent < 3);
      if (d_sent < 3) set_d(dexp[d_sent]);
      #1;
      if (auto_in_d_valid) begin
        if (got < 3) chk($sformatf("dbp_beat%0d", got), 128'(d_out_vec), 128'(dexp[got]));
        got++;
      end
      odf = auto_out_d_valid && auto_out_d_ready;
      end_cycle();
      if (odf) d_sent++;
    end
    chk("dbp_count", 128'(got), 128'(3));

    // Inflight cap, release by one D, simultaneous A/D fire keeps the count
    do_reset();
    feed_en = 1'b1;
    feed_n = 12;
    auto_out_a_ready = 1'b1;
    fires = 0;
    for (int c = 0; c < 30; c++) begin
      begin_cycle();
      #1;
      if (auto_out_a_valid && auto_out_a_ready) fires++;
      end_cycle();
    end
    chk("cap_fires", 128'(fires), 128'(8));
    begin_cycle();
    #1;
    chk("cap_gated", 128'(auto_out_a_valid), 128'(0));
    end_cycle();
    for (int k = 0; k < 2; k++) begin
      begin_cycle();
      auto_out_d_valid = 1'b1;
      set_d({3'd1, 2'd0, 3'd3, 7'(k), 3'd1, 1'b0, 64'(k), 1'b0});
      #1;
      end_cycle();
    end
    begin_cycle();
    auto_out_d_valid = 1'b0;
    auto_in_d_ready = 1'b1;
    #1;
    chk("cap_d_avail", 128'(auto_in_d_valid), 128'(1));
    chk("cap_still_gated", 128'(auto_out_a_valid), 128'(0));
    end_cycle();
    begin_cycle();
    #1;
    chk("cap_ninth_valid", 128'(auto_out_a_valid), 128'(1));
    chk("cap_ninth_src", 128'(auto_out_a_bits_source), 128'(8));
    chk("cap_both_fire_d", 128'(auto_in_d_valid), 128'(1));
    end_cycle();
    begin_cycle();
    #1;
    chk("cap_tenth_valid", 128'(auto_out_a_valid), 128'(1));
    chk("cap_tenth_src", 128'(auto_out_a_bits_source), 128'(9));
    chk("cap_d_drained", 128'(auto_in_d_valid), 128'(0));
    end_cycle();
    begin_cycle();
    #1;
    chk("cap_regated", 128'(auto_out_a_valid), 128'(0));
    end_cycle();

    // Randomized traffic against a queue model
    do_reset();
    infl = 0;
    a_hold = 1'b0;
    d_hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (!a_hold) begin
        auto_in_a_valid = ($urandom_range(0, 2) != 0);
        set_a(rand_a());
      end
      auto_out_a_ready = ($urandom_range(0, 3) != 0);
      if (!d_hold) begin
        if (pool.size() > 0 && $urandom_range(0, 1) == 1) begin
          auto_out_d_valid = 1'b1;
          set_d(rand_d(pool[0]));
        end else begin
          auto_out_d_valid = 1'b0;
        end
      end
      auto_in_d_ready = ($urandom_range(0, 3) != 0);
      #1;
      e_oav   = ((aq.size() > 0) || (FLOW && auto_in_a_valid)) && (infl < MAX_INFLIGHT);
      e_ahead = (aq.size() > 0) ? aq[0] : a_in_vec;
      e_iar   = (aq.size() < A_DEPTH);
      e_idv   = (dq.size() > 0) || (FLOW && auto_out_d_valid);
      e_dhead = (dq.size() > 0) ? dq[0] : d_in_vec;
      e_odr   = (dq.size() < D_DEPTH);
      chk("rnd_out_a_valid", 128'(auto_out_a_valid), 128'(e_oav));
      chk("rnd_in_a_ready", 128'(auto_in_a_ready), 128'(e_iar));
      chk("rnd_in_d_valid", 128'(auto_in_d_valid), 128'(e_idv));
      chk("rnd_out_d_ready", 128'(auto_out_d_ready), 128'(e_odr));
      if (e_oav) chk("rnd_out_a_bits", 128'(a_out_vec), 128'(e_ahead));
      if (e_idv) chk("rnd_in_d_bits", 128'(d_out_vec), 128'(e_dhead));
      oaf = e_oav && auto_out_a_ready;
      iaf = auto_in_a_valid && e_iar;
      idf = e_idv && auto_in_d_ready;
      odf = auto_out_d_valid && e_odr;
      a_byp = FLOW && (aq.size() == 0) && oaf;
      d_byp = FLOW && (dq.size() == 0) && idf;
      if (oaf) pool.push_back(e_ahead[111:105]);
      if (oaf && !a_byp) void'(aq.pop_front());
      if (iaf && !a_byp) aq.push_back(a_in_vec);
      if (idf && !d_byp) void'(dq.pop_front());
      if (odf && !d_byp) dq.push_back(d_in_vec);
      if (odf) void'(pool.pop_front());
      infl = infl + (oaf ? 1 : 0) - (idf ? 1 : 0);
      if (infl < 0) infl = 0;
      a_hold = auto_in_a_valid && !iaf;
      d_hold = auto_out_d_valid && !odf;
      @(posedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
